// File: rtl/branch_pc_unit.sv
// Branch resolution, PC register and instruction-SRAM fetch sequencing.
// Optional build macro BRANCH_STATS_EN adds retired-branch and taken-branch counters.
module branch_pc_unit #(
    parameter int                   PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_brc_equal,
    input  logic                i_brc_less,
    input  logic                i_rs1_sign,
    input  logic                i_rs2_sign,
    input  logic [2:0]          i_funct3,
    input  logic                i_is_branch,
    input  logic                i_is_jal,
    input  logic                i_is_jalr,
    input  logic [PC_WIDTH-1:0] i_target,
    input  logic                i_stall,
    input  logic                i_imem_ack,
    output logic                o_imem_req,
    output logic [PC_WIDTH-1:0] o_pc,
    output logic [PC_WIDTH-1:0] o_pc_four,
    output logic                o_retire,
    output logic                o_taken,
    output logic                o_trap
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]         o_branch_cnt,
    output logic [31:0]         o_taken_cnt
`endif
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_TRAP  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                retire_q, retire_d;
    logic                taken_q, taken_d;
    logic                trap_q, trap_d;

    logic                slt;
    logic                cond;
    logic                take;
    logic                branch_eff;
    logic [PC_WIDTH-1:0] tgt;
    logic [PC_WIDTH-1:0] pc_four;

    assign pc_four = pc_q + PC_WIDTH'(4);

    always_comb begin
        // The comparator is unsigned; differing sign bits decide signed order directly.
        slt = (i_rs1_sign != i_rs2_sign) ? i_rs1_sign : i_brc_less;
        case (i_funct3)
            3'b000:  cond = i_brc_equal;
            3'b001:  cond = !i_brc_equal;
            3'b100:  cond = slt;
            3'b101:  cond = !slt;
            3'b110:  cond = i_brc_less;
            3'b111:  cond = !i_brc_less;
            default: cond = 1'b0;
        endcase
        branch_eff = i_is_branch && !i_is_jal && !i_is_jalr;
        take       = i_is_jalr || i_is_jal || (i_is_branch && cond);
        tgt        = i_is_jalr ? {i_target[PC_WIDTH-1:1], 1'b0} : i_target;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        retire_d = 1'b0;
        taken_d  = taken_q;
        trap_d   = trap_q;
        case (state_q)
            S_FETCH: begin
                if (i_imem_ack) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (!i_stall) begin
                    if (take && tgt[1]) begin
                        state_d = S_TRAP;
                        trap_d  = 1'b1;
                    end else begin
                        pc_d     = take ? tgt : pc_four;
                        retire_d = 1'b1;
                        taken_d  = take;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            retire_q <= 1'b0;
            taken_q  <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            retire_q <= retire_d;
            taken_q  <= taken_d;
            trap_q   <= trap_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] taken_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else if (retire_d && branch_eff) begin
            branch_cnt_q <= branch_cnt_q + 32'd1;
            if (take) taken_cnt_q <= taken_cnt_q + 32'd1;
        end
    end

    assign o_branch_cnt = branch_cnt_q;
    assign o_taken_cnt  = taken_cnt_q;
`endif

    assign o_imem_req = (state_q == S_FETCH) && !i_rst;
    assign o_pc       = pc_q;
    assign o_pc_four  = pc_four;
    assign o_retire   = retire_q;
    assign o_taken    = taken_q;
    assign o_trap     = trap_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: expected PC/taken pushed at EXEC, popped on o_retire.
module tb_branch_pc_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_brc_equal, i_brc_less, i_rs1_sign, i_rs2_sign;
    logic [2:0]  i_funct3;
    logic        i_is_branch, i_is_jal, i_is_jalr;
    logic [31:0] i_target;
    logic        i_stall, i_imem_ack;
    logic        o_imem_req;
    logic [31:0] o_pc, o_pc_four;
    logic        o_retire, o_taken, o_trap;
`ifdef BRANCH_STATS_EN
    logic [31:0] o_branch_cnt, o_taken_cnt;
`endif

    branch_pc_unit #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_brc_equal(i_brc_equal), .i_brc_less(i_brc_less),
        .i_rs1_sign(i_rs1_sign), .i_rs2_sign(i_rs2_sign),
        .i_funct3(i_funct3),
        .i_is_branch(i_is_branch), .i_is_jal(i_is_jal), .i_is_jalr(i_is_jalr),
        .i_target(i_target), .i_stall(i_stall), .i_imem_ack(i_imem_ack),
        .o_imem_req(o_imem_req), .o_pc(o_pc), .o_pc_four(o_pc_four),
        .o_retire(o_retire), .o_taken(o_taken), .o_trap(o_trap)
`ifdef BRANCH_STATS_EN
        , .o_branch_cnt(o_branch_cnt), .o_taken_cnt(o_taken_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        tk;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          n_push = 0;
    int          n_ret = 0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_bc = 32'h0;
    logic [31:0] m_tc = 32'h0;
    logic        exp_trap = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (o_retire === 1'b1) begin
            exp_t e;
            n_ret++;
            if (sb.size() == 0) begin
                chk("unexpected_retire", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("retire_pc", o_pc, e.pc);
                chk("retire_taken", 32'(o_taken), 32'(e.tk));
            end
        end
    end

    // Entered just after a rising edge with the DUT in FETCH; leaves just after the retire/trap edge.
    task automatic run_instr(input int ack_dly, input int stall_n,
                             input logic br, input logic jal, input logic jalr,
                             input logic [2:0] f3, input logic [31:0] rs1,
                             input logic [31:0] rs2, input logic [31:0] tgt);
        logic        cond, take, br_eff;
        logic [31:0] t, nxt;
        case (f3)
            3'b000:  cond = (rs1 == rs2);
            3'b001:  cond = (rs1 != rs2);
            3'b100:  cond = ($signed(rs1) <  $signed(rs2));
            3'b101:  cond = ($signed(rs1) >= $signed(rs2));
            3'b110:  cond = (rs1 <  rs2);
            3'b111:  cond = (rs1 >= rs2);
            default: cond = 1'b0;
        endcase
        take   = jalr | jal | (br & cond);
        br_eff = br & !jal & !jalr;
        t      = jalr ? {tgt[31:1], 1'b0} : tgt;
        nxt    = take ? t : m_pc + 32'd4;

        i_is_branch = br; i_is_jal = jal; i_is_jalr = jalr; i_funct3 = f3;
        i_brc_equal = (rs1 == rs2); i_brc_less = (rs1 < rs2);
        i_rs1_sign = rs1[31]; i_rs2_sign = rs2[31]; i_target = tgt;
        i_stall = 1'b0; i_imem_ack = 1'b0;
        for (int k = 0; k < ack_dly; k++) begin
            @(negedge i_clk);
            chk("fetch_req", 32'(o_imem_req), 32'd1);
            chk("fetch_pc", o_pc, m_pc);
            @(posedge i_clk); #1;
        end
        i_imem_ack = 1'b1;
        @(negedge i_clk);
        chk("fetch_req_ack", 32'(o_imem_req), 32'd1);
        @(posedge i_clk); #1;
        i_imem_ack = 1'b0;
        i_stall = (stall_n > 0);
        for (int k = 0; k < stall_n; k++) begin
            @(negedge i_clk);
            chk("stall_pc", o_pc, m_pc);
            chk("stall_retire", 32'(o_retire), 32'd0);
            @(posedge i_clk); #1;
        end
        i_stall = 1'b0;
        @(negedge i_clk);
        chk("exec_req", 32'(o_imem_req), 32'd0);
        if (take && t[1]) begin
            exp_trap = 1'b1;
        end else begin
            sb.push_back('{pc: nxt, tk: take});
            n_push++;
            m_pc = nxt;
            if (br_eff) m_bc = m_bc + 32'd1;
            if (br_eff && take) m_tc = m_tc + 32'd1;
        end
        @(posedge i_clk); #1;
        i_is_branch = 1'b0; i_is_jal = 1'b0; i_is_jalr = 1'b0;
    endtask

    task automatic chk_stats;
`ifdef BRANCH_STATS_EN
        chk("branch_cnt", o_branch_cnt, m_bc);
        chk("taken_cnt", o_taken_cnt, m_tc);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_brc_equal = 0; i_brc_less = 0; i_rs1_sign = 0; i_rs2_sign = 0;
        i_funct3 = 3'b0; i_is_branch = 0; i_is_jal = 0; i_is_jalr = 0;
        i_target = 32'h0; i_stall = 0; i_imem_ack = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_req", 32'(o_imem_req), 32'd0);
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_retire", 32'(o_retire), 32'd0);
        chk("rst_taken", 32'(o_taken), 32'd0);
        chk("rst_trap", 32'(o_trap), 32'd0);
        chk_stats();
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_imem_ack = 1'b0;

        // ack in third FETCH cycle, plain instruction
        run_instr(2, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0);
        // BLT signed vs BLTU with the same operands
        run_instr(0, 0, 1, 0, 0, 3'b100, 32'h8000_0000, 32'h5, 32'h100);
        run_instr(1, 0, 1, 0, 0, 3'b110, 32'h8000_0000, 32'h5, 32'h100);
        // BEQ under a three-cycle stall
        run_instr(0, 3, 1, 0, 0, 3'b000, 32'h7, 32'h7, 32'h40);

        // reset while stalled in EXEC
        i_is_branch = 1; i_funct3 = 3'b000; i_brc_equal = 1; i_target = 32'h80;
        i_stall = 1; i_imem_ack = 1;
        @(posedge i_clk); #1;
        i_imem_ack = 0;
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("rstx_req", 32'(o_imem_req), 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_stall = 0; i_is_branch = 0;
        m_pc = 32'h0; m_bc = 32'h0; m_tc = 32'h0;
        @(negedge i_clk);
        chk("rstx_pc", o_pc, 32'h0);
        chk("rstx_req_after", 32'(o_imem_req), 32'd1);
        chk("rstx_retire", 32'(o_retire), 32'd0);
        chk_stats();
        @(posedge i_clk); #1;

        run_instr(0, 0, 1, 0, 0, 3'b001, 32'h1, 32'h1, 32'h80);          // BNE not taken
        run_instr(0, 1, 1, 0, 0, 3'b101, 32'h5, 32'hFFFF_FFFF, 32'h300); // BGE taken
        run_instr(0, 0, 1, 0, 0, 3'b111, 32'h5, 32'hFFFF_FFFF, 32'h300); // BGEU not taken
        run_instr(0, 0, 1, 0, 0, 3'b010, 32'h3, 32'h3, 32'h300);         // funct3 010 never
        run_instr(0, 0, 1, 1, 0, 3'b001, 32'h3, 32'h3, 32'h500);         // JAL over branch
        run_instr(0, 0, 0, 1, 1, 3'b000, 32'h0, 32'h0, 32'h601);         // JALR masks bit 0
        run_instr(0, 0, 1, 0, 0, 3'b100, 32'h3, 32'h9, 32'hFFFF_FFFC);   // BLT to top of space
        run_instr(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0);           // wraps to 0
        @(negedge i_clk);
        chk("wrap_pc", o_pc, 32'h0);
        chk("wrap_pc_four", o_pc_four, 32'h4);
        @(posedge i_clk); #1;
        run_instr(0, 0, 1, 0, 0, 3'b110, 32'h9, 32'h3, 32'h0);           // BLTU not taken
        chk_stats();

        // misaligned JALR target traps
        run_instr(0, 0, 0, 0, 1, 3'b000, 32'h0, 32'h0, 32'h203);
        chk("trap_expected", 32'(exp_trap), 32'd1);
        i_imem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("trap_flag", 32'(o_trap), 32'd1);
            chk("trap_pc", o_pc, m_pc);
            chk("trap_req", 32'(o_imem_req), 32'd0);
            @(posedge i_clk); #1;
        end
        chk_stats();
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_imem_ack = 1'b0;
        @(negedge i_clk);
        chk("trap_cleared", 32'(o_trap), 32'd0);
        chk("trap_rst_pc", o_pc, 32'h0);
        chk("retire_count", 32'(n_ret), 32'(n_push));
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
Downstream consumer of the branch comparator's equal/less flags in the single-cycle core with SRAM.
- Resolves the RV32I branch condition from funct3, including signed compare derived from operand sign bits, since the comparator is unsigned.
- Selects jump/branch target or PC+4, owns the PC register, and sequences the instruction-SRAM fetch handshake.
- Traps on misaligned taken targets.

Parameters:
PC_WIDTH, 32, width of PC and target buses
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_brc_equal  in  1  comparator: rs1 == rs2
i_brc_less  in  1  comparator: rs1 < rs2 (unsigned)
i_rs1_sign  in  1  rs1[PC_WIDTH-1]
i_rs2_sign  in  1  rs2[PC_WIDTH-1]
i_funct3  in  3  instruction funct3
i_is_branch  in  1  current instruction is a B-type
i_is_jal  in  1  current instruction is JAL
i_is_jalr  in  1  current instruction is JALR
i_target  in  PC_WIDTH  ALU-computed target (pc+imm or rs1+imm)
i_stall  in  1  execute stage held (e.g. data SRAM not ready)
i_imem_ack  in  1  instruction SRAM has returned the word at o_pc
o_imem_req  out  1  fetch request; o_pc stable while high
o_pc  out  PC_WIDTH  current PC
o_pc_four  out  PC_WIDTH  o_pc + 4, combinational, for link writeback
o_retire  out  1  one-cycle pulse: instruction at previous PC retired
o_taken  out  1  registered, valid with o_retire: retired instruction redirected PC
o_trap  out  1  sticky misaligned-target trap

Behaviour:
- Reset (i_rst high at a clock edge, in any state):
  - o_pc = RESET_PC, state = FETCH.
  - o_retire = 0, o_taken = 0, o_trap = 0.
  - o_imem_req is 0 while i_rst is high.
  - A pending ack is discarded.
- States: FETCH, EXEC, TRAP.
- FETCH:
  - o_imem_req = 1, o_pc held.
  - i_imem_ack = 1 -> EXEC next cycle. Ack may arrive in the first FETCH cycle, giving a minimum 1 cycle in FETCH.
- EXEC:
  - o_imem_req = 0.
  - Signed less: slt = (i_rs1_sign != i_rs2_sign) ? i_rs1_sign : i_brc_less.
  - Branch condition by funct3: 000 eq; 001 !eq; 100 slt; 101 !slt; 110 less; 111 !less; 010/011 never taken.
  - Priority if several type flags are high: jalr > jal > branch.
  - take = is_jalr | is_jal | (is_branch & cond).
  - tgt = is_jalr ? (i_target & ~1) : i_target.
  - i_stall = 1: stay in EXEC; no PC update, no retire; inputs are re-evaluated every cycle.
  - i_stall = 0 and take and tgt[1] = 1: go to TRAP; o_trap <= 1, o_pc unchanged, no retire.
  - Otherwise: o_pc <= take ? tgt : o_pc + 4; o_retire <= 1 for one cycle; o_taken <= take; go to FETCH.
- TRAP: o_imem_req = 0, o_pc frozen, o_trap stays 1 until reset.
- i_imem_ack outside FETCH is ignored.
- PC arithmetic is modulo 2^PC_WIDTH: 0xFFFF_FFFC + 4 = 0x0000_0000.
- Throughput: 1 instruction per 2 cycles minimum (FETCH+ack, EXEC).

Optional Feature:
BRANCH_STATS_EN
- Defined:
  - Adds o_branch_cnt[31:0], incremented on each retire with is_branch (after priority resolution).
  - Adds o_taken_cnt[31:0], incremented when that retire also has take = 1.
  - Both counters reset to 0 and wrap at 2^32.
  - Neither counter counts trapped or stalled cycles.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, RESET_PC=0: release reset; ack in the 3rd FETCH cycle with a non-branch, no stall -> o_imem_req=1 during FETCH, EXEC for 1 cycle, then o_pc=0x4, o_retire pulse, o_taken=0.
- BLT signed: rs1_sign=1, rs2_sign=0, brc_less=0, funct3=100, target 0x100 -> o_pc=0x100, o_taken=1. Same operands with funct3=110 (BLTU) -> o_pc=old+4, o_taken=0.
- JALR with i_target=0x203 -> masked tgt 0x202, bit1 set -> o_trap=1, o_pc unchanged, o_imem_req stays 0 and acks are ignored until reset.
- BEQ, eq=1, target 0x40, i_stall high for 3 cycles -> o_pc held, no o_retire during the stall. Stall drops -> o_pc=0x40, single o_retire pulse.
- o_pc=0xFFFF_FFFC, non-branch retire -> o_pc=0x0000_0000, o_pc_four=0x4.
- Reset asserted in EXEC while stalled -> next cycle FETCH, o_pc=RESET_PC, no o_retire. With BRANCH_STATS_EN, counters = 0.
